// File: rtl/inv_round_engine.sv
// Iterative AES-128 inverse cipher: one decryption round per clock around a single state register,
// with round keys read combinationally from an external key store by index.

module inv_shift_rows (
    input  logic [127:0] data,
    output logic [127:0] result
);
    // Row r of each column takes its byte from column (c - r) mod 4; byte index = 4*col + row.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign result[127-8*(4*c+r) -: 8] = data[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end
endmodule

module inv_sub_bytes (
    input  logic [127:0] data,
    output logic [127:0] result
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign result[127-8*i -: 8] = INV_SBOX[data[127-8*i -: 8]];
    end
endmodule

module inv_mix_columns (
    input  logic [127:0] data,
    output logic [127:0] result
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant built from x8/x4/x2/x1 terms (9, b, d, e).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data[127-32*c -: 8];
        assign a1 = data[119-32*c -: 8];
        assign a2 = data[111-32*c -: 8];
        assign a3 = data[103-32*c -: 8];
        assign result[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
        assign result[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
        assign result[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
        assign result[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
endmodule

module key_add (
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = data ^ key;
endmodule

module inv_round_engine #(
    parameter int unsigned BLOCK_LENGTH = 128,
    parameter int unsigned KEY_IDX_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] CT_IN,
    output logic [KEY_IDX_W-1:0]    key_idx,
    input  logic [BLOCK_LENGTH-1:0] ROUND_KEY,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] PT_OUT,
    output logic                    busy
);
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LAST_KEY   = 10;
    localparam int unsigned FIRST_RND  = 9;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t                    fsm, fsm_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [BLOCK_LENGTH-1:0] state_reg, state_nxt;
    logic [BLOCK_LENGTH-1:0] pt_nxt;
    logic                    out_valid_nxt;
    logic                    accept;

    logic [BLOCK_LENGTH-1:0] shifted, subbed, keyed, mixed, loaded;

    // Shared datapath: ROUND feeds keyed through InvMixColumns, FINAL takes keyed directly.
    inv_shift_rows  u_shift (.data(state_reg), .result(shifted));
    inv_sub_bytes   u_sub   (.data(shifted),   .result(subbed));
    key_add         u_rkey  (.data(subbed),    .key(ROUND_KEY), .result(keyed));
    inv_mix_columns u_mix   (.data(keyed),     .result(mixed));
    key_add         u_ikey  (.data(CT_IN),     .key(ROUND_KEY), .result(loaded));

    assign in_ready = (fsm == IDLE) | ((fsm == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (fsm == ROUND) | (fsm == FINAL);

    always_comb begin
        key_idx = KEY_IDX_W'(LAST_KEY);
        case (fsm)
            ROUND:   key_idx = KEY_IDX_W'(cnt);
            FINAL:   key_idx = '0;
            default: key_idx = KEY_IDX_W'(LAST_KEY);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            state_reg <= '0;
            PT_OUT    <= '0;
            out_valid <= 1'b0;
        end else begin
            fsm       <= fsm_nxt;
            cnt       <= cnt_nxt;
            state_reg <= state_nxt;
            PT_OUT    <= pt_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_comb begin
        fsm_nxt       = fsm;
        cnt_nxt       = cnt;
        state_nxt     = state_reg;
        pt_nxt        = PT_OUT;
        out_valid_nxt = out_valid;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    state_nxt = loaded;
                    cnt_nxt   = CNT_W'(FIRST_RND);
                    fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                state_nxt = mixed;
                if (cnt == CNT_W'(1)) begin
                    fsm_nxt = FINAL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            FINAL: begin
                pt_nxt        = keyed;
                out_valid_nxt = 1'b1;
                fsm_nxt       = DONE;
            end
            DONE: begin
                // A same-cycle accept reloads immediately so blocks stream without a bubble.
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (accept) begin
                        state_nxt = loaded;
                        cnt_nxt   = CNT_W'(FIRST_RND);
                        fsm_nxt   = ROUND;
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_inv_round_engine.sv
// Bench for inv_round_engine: FIPS-197 vectors, latency, key index order, backpressure,
// back-to-back streaming, mid-block reset and ignored input during rounds.

module tb_inv_round_engine;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] CT_IN;
    logic [3:0]   key_idx;
    logic [127:0] ROUND_KEY;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] PT_OUT;
    logic         busy;

    logic [127:0] rk [2][11];
    logic         key_sel;
    logic [127:0] exp_q [$];
    int           hs_q  [$];
    int           cyc;
    int           n_tests;
    int           n_fail;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    inv_round_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .CT_IN(CT_IN),
        .key_idx(key_idx), .ROUND_KEY(ROUND_KEY), .out_valid(out_valid), .out_ready(out_ready),
        .PT_OUT(PT_OUT), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ROUND_KEY = (key_idx <= 4'd10) ? rk[key_sel][key_idx] : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent key schedule: forward S-box derived from GF(2^8) inverse plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Scoreboard consumer: one pop per output handshake.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check("sb_nonempty", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) check("pt_out", PT_OUT, exp_q.pop_front());
            hs_q.push_back(cyc);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] ct, input logic sel, input logic [127:0] exp,
                        input logic hold, output int acc_cyc);
        int n;
        n = 0;
        in_valid = hold;
        CT_IN    = ct;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_timeout", 128'(n >= 100), 128'(0));
        key_sel  = sel;
        in_valid = 1'b1;
        CT_IN    = ct;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        acc_cyc  = cyc;
        in_valid = hold;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_timeout", 128'(n >= 40), 128'(0));
    endtask

    int a0, a1, lat, h0;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst = 1'b0; in_valid = 1'b0; CT_IN = '0; out_ready = 1'b1; key_sel = 1'b0;
        expand_key(0, KEY_A);
        expand_key(1, KEY_B);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_pt_out",    PT_OUT,          128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_key_idx",   128'(key_idx),   128'(10));
        rst = 1'b1;
        @(posedge clk); #1;

        // Vector A with latency measurement.
        send(CT_A, 1'b0, PT_A, 1'b0, a0);
        wait_out(lat);
        check("latency", 128'(lat), 128'(11));
        @(posedge clk); #1;

        // Vector B with key index sequence.
        check("kidx_c0", 128'(key_idx), 128'(10));
        send(CT_B, 1'b1, PT_B, 1'b0, a0);
        for (int i = 9; i >= 0; i--) begin
            check("kidx_seq", 128'(key_idx), 128'(i));
            check("busy_rnd", 128'(busy), 128'(1));
            @(posedge clk); #1;
        end
        check("b_out_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;

        // Backpressure.
        out_ready = 1'b0;
        send(CT_A, 1'b0, PT_A, 1'b0, a0);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_pt",    PT_OUT,          PT_A);
            check("bp_ready", 128'(in_ready),  128'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drop", 128'(out_valid), 128'(0));
        check("bp_idle", 128'(in_ready),  128'(1));

        // Back-to-back with in_valid held high.
        hs_q.delete();
        send(CT_A, 1'b0, PT_A, 1'b1, a0);
        send(CT_B, 1'b1, PT_B, 1'b0, a1);
        check("b2b_accept_gap", 128'(a1 - a0), 128'(11));
        wait_out(lat);
        @(posedge clk); #1;
        check("b2b_hs_count", 128'(hs_q.size()), 128'(2));
        if (hs_q.size() == 2) begin
            h0 = hs_q.pop_front();
            check("b2b_hs_gap", 128'(hs_q.pop_front() - h0), 128'(11));
        end

        // Reset in the middle of a block.
        send(CT_B, 1'b1, PT_B, 1'b0, a0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_pt",    PT_OUT,          128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_ready", 128'(in_ready),  128'(1));
        check("mrst_busy",  128'(busy),      128'(0));
        check("mrst_valid2", 128'(out_valid), 128'(0));
        send(CT_A, 1'b0, PT_A, 1'b0, a0);
        wait_out(lat);
        check("mrst_latency", 128'(lat), 128'(11));
        @(posedge clk); #1;

        // Random in_valid/CT_IN during rounds must not disturb the block.
        send(CT_B, 1'b1, PT_B, 1'b0, a0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            CT_IN    = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_out(lat);
        @(posedge clk); #1;

        check("sb_left", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
